// File: rtl/ins_pkg.sv
// rtl/ins_pkg.sv - RV64 instruction types, formats and opcode fields shared by encoder and decoder
package ins_pkg;

  localparam int TYPE_W = 23;

  typedef logic [TYPE_W-1:0] ins_type_t;
  typedef logic [4:0]        ins_fmt_t;

  localparam ins_type_t T_JAL  = 23'b1 << 22;
  localparam ins_type_t T_JALR = 23'b1 << 21;
  localparam ins_type_t T_BEQ  = 23'b1 << 20;
  localparam ins_type_t T_BNE  = 23'b1 << 19;
  localparam ins_type_t T_LD   = 23'b1 << 18;
  localparam ins_type_t T_SD   = 23'b1 << 17;
  localparam ins_type_t T_ADDI = 23'b1 << 16;
  localparam ins_type_t T_SLTI = 23'b1 << 15;
  localparam ins_type_t T_XORI = 23'b1 << 14;
  localparam ins_type_t T_ORI  = 23'b1 << 13;
  localparam ins_type_t T_ANDI = 23'b1 << 12;
  localparam ins_type_t T_SLLI = 23'b1 << 11;
  localparam ins_type_t T_SRLI = 23'b1 << 10;
  localparam ins_type_t T_SRAI = 23'b1 << 9;
  localparam ins_type_t T_ADD  = 23'b1 << 8;
  localparam ins_type_t T_SUB  = 23'b1 << 7;
  localparam ins_type_t T_SLL  = 23'b1 << 6;
  localparam ins_type_t T_SLT  = 23'b1 << 5;
  localparam ins_type_t T_XOR  = 23'b1 << 4;
  localparam ins_type_t T_SRL  = 23'b1 << 3;
  localparam ins_type_t T_SRA  = 23'b1 << 2;
  localparam ins_type_t T_OR   = 23'b1 << 1;
  localparam ins_type_t T_AND  = 23'b1 << 0;

  localparam ins_fmt_t FMT_R = 5'b10000;
  localparam ins_fmt_t FMT_I = 5'b01000;
  localparam ins_fmt_t FMT_S = 5'b00100;
  localparam ins_fmt_t FMT_B = 5'b00010;
  localparam ins_fmt_t FMT_J = 5'b00001;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_LSD  = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WR   = 1'b1
  } enc_state_t;

  function automatic logic is_onehot(input ins_type_t t);
    return (t != '0) && ((t & (t - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/ins_word_enc.sv
// rtl/ins_word_enc.sv - combinational packing of one decoded instruction into a 32-bit RV64 word
module ins_word_enc
  import ins_pkg::*;
(
  input  logic [22:0] in_type,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [20:0] in_imm,
  output logic [31:0] word,
  output logic        legal
);

  ins_fmt_t   fmt;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       shamt;

  assign legal = is_onehot(in_type);

  always_comb begin
    fmt    = '0;
    opcode = '0;
    f3     = '0;
    f7     = F7_BASE;
    shamt  = 1'b0;
    case (in_type)
      T_JAL:  begin fmt = FMT_J; opcode = OPC_JAL; end
      T_JALR: begin fmt = FMT_I; opcode = OPC_JALR;   f3 = F3_ADD; end
      T_BEQ:  begin fmt = FMT_B; opcode = OPC_BRANCH; f3 = F3_BEQ; end
      T_BNE:  begin fmt = FMT_B; opcode = OPC_BRANCH; f3 = F3_BNE; end
      T_LD:   begin fmt = FMT_I; opcode = OPC_LOAD;   f3 = F3_LSD; end
      T_SD:   begin fmt = FMT_S; opcode = OPC_STORE;  f3 = F3_LSD; end
      T_ADDI: begin fmt = FMT_I; opcode = OPC_OP_IMM; f3 = F3_ADD; end
      T_SLTI: begin fmt = FMT_I; opcode = OPC_OP_IMM; f3 = F3_SLT; end
      T_XORI: begin fmt = FMT_I; opcode = OPC_OP_IMM; f3 = F3_XOR; end
      T_ORI:  begin fmt = FMT_I; opcode = OPC_OP_IMM; f3 = F3_OR;  end
      T_ANDI: begin fmt = FMT_I; opcode = OPC_OP_IMM; f3 = F3_AND; end
      T_SLLI: begin fmt = FMT_I; opcode = OPC_OP_IMM; f3 = F3_SLL; shamt = 1'b1; end
      T_SRLI: begin fmt = FMT_I; opcode = OPC_OP_IMM; f3 = F3_SR;  shamt = 1'b1; end
      T_SRAI: begin fmt = FMT_I; opcode = OPC_OP_IMM; f3 = F3_SR;  shamt = 1'b1; f7 = F7_ALT; end
      T_ADD:  begin fmt = FMT_R; opcode = OPC_OP; f3 = F3_ADD; end
      T_SUB:  begin fmt = FMT_R; opcode = OPC_OP; f3 = F3_ADD; f7 = F7_ALT; end
      T_SLL:  begin fmt = FMT_R; opcode = OPC_OP; f3 = F3_SLL; end
      T_SLT:  begin fmt = FMT_R; opcode = OPC_OP; f3 = F3_SLT; end
      T_XOR:  begin fmt = FMT_R; opcode = OPC_OP; f3 = F3_XOR; end
      T_SRL:  begin fmt = FMT_R; opcode = OPC_OP; f3 = F3_SR;  end
      T_SRA:  begin fmt = FMT_R; opcode = OPC_OP; f3 = F3_SR;  f7 = F7_ALT; end
      T_OR:   begin fmt = FMT_R; opcode = OPC_OP; f3 = F3_OR;  end
      T_AND:  begin fmt = FMT_R; opcode = OPC_OP; f3 = F3_AND; end
      default: ;
    endcase
  end

  // Shift immediates carry funct6 = funct7[6:1] above a 6-bit shamt (RV64)
  always_comb begin
    word = '0;
    case (fmt)
      FMT_R: word = {f7, in_rs2, in_rs1, f3, in_rd, opcode};
      FMT_I: word = shamt ? {f7[6:1], in_imm[5:0], in_rs1, f3, in_rd, opcode}
                          : {in_imm[11:0], in_rs1, f3, in_rd, opcode};
      FMT_S: word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opcode};
      FMT_B: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                     in_imm[4:1], in_imm[11], opcode};
      FMT_J: word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opcode};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/ins_encoder.sv
// rtl/ins_encoder.sv - handshaked instruction encoder writing words to consecutive memory addresses
module ins_encoder
  import ins_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR = 30'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [22:0] in_type,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [20:0] in_imm,
  output logic        mem_wen,
  input  logic        mem_ready,
  output logic [29:0] mem_addr_I,
  output logic [31:0] mem_wdata_I,
  output logic        err
);

  enc_state_t  state, state_nxt;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;

  ins_word_enc u_word_enc (
    .in_type (in_type),
    .in_rd   (in_rd),
    .in_rs1  (in_rs1),
    .in_rs2  (in_rs2),
    .in_imm  (in_imm),
    .word    (enc_word),
    .legal   (enc_legal)
  );

  assign in_ready = (state == ST_IDLE) && !start;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && enc_legal) state_nxt = ST_WR;
      ST_WR:   if (mem_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (start) state_nxt = ST_IDLE;
  end

  // Illegal accepts complete the handshake but only raise the sticky flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wen     <= 1'b0;
      mem_addr_I  <= BASE_ADDR;
      mem_wdata_I <= '0;
      err         <= 1'b0;
    end else if (start) begin
      mem_wen    <= 1'b0;
      mem_addr_I <= BASE_ADDR;
      err        <= 1'b0;
    end else begin
      mem_wen <= (state_nxt == ST_WR);
      if (accept) begin
        if (enc_legal) mem_wdata_I <= enc_word;
        else           err         <= 1'b1;
      end
      if (state == ST_WR && mem_ready) mem_addr_I <= mem_addr_I + 30'd1;
    end
  end

endmodule

// File: tb/tb_ins_encoder.sv
// tb/tb_ins_encoder.sv - scoreboard bench for ins_encoder with directed and randomized instructions
module tb_ins_encoder;

  localparam logic [29:0] BASE = 30'h3FFFFFFE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [22:0] in_type = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [20:0] in_imm = '0;
  logic        mem_wen;
  logic        mem_ready = 1'b1;
  logic [29:0] mem_addr_I;
  logic [31:0] mem_wdata_I;
  logic        err;

  ins_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_wen(mem_wen), .mem_ready(mem_ready), .mem_addr_I(mem_addr_I),
    .mem_wdata_I(mem_wdata_I), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [29:0] m_addr = BASE;
  logic        m_err = 1'b0;
  bit          rdy_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Reference encoder built from field positions by plain arithmetic
  function automatic logic [31:0] ref_enc(input int k, input int rd, input int rs1,
                                          input int rs2, input logic [20:0] imm);
    longint op = 0, f3 = 0, f7 = 0, u, w;
    byte fmt = "R";
    u = longint'(imm);
    case (k)
      22: begin fmt = "J"; op = 'h6F; end
      21: begin fmt = "I"; op = 'h67; f3 = 0; end
      20: begin fmt = "B"; op = 'h63; f3 = 0; end
      19: begin fmt = "B"; op = 'h63; f3 = 1; end
      18: begin fmt = "I"; op = 'h03; f3 = 3; end
      17: begin fmt = "S"; op = 'h23; f3 = 3; end
      16: begin fmt = "I"; op = 'h13; f3 = 0; end
      15: begin fmt = "I"; op = 'h13; f3 = 2; end
      14: begin fmt = "I"; op = 'h13; f3 = 4; end
      13: begin fmt = "I"; op = 'h13; f3 = 6; end
      12: begin fmt = "I"; op = 'h13; f3 = 7; end
      11: begin fmt = "H"; op = 'h13; f3 = 1; end
      10: begin fmt = "H"; op = 'h13; f3 = 5; end
      9:  begin fmt = "H"; op = 'h13; f3 = 5; f7 = 'h10; end
      8:  begin op = 'h33; f3 = 0; end
      7:  begin op = 'h33; f3 = 0; f7 = 'h20; end
      6:  begin op = 'h33; f3 = 1; end
      5:  begin op = 'h33; f3 = 2; end
      4:  begin op = 'h33; f3 = 4; end
      3:  begin op = 'h33; f3 = 5; end
      2:  begin op = 'h33; f3 = 5; f7 = 'h20; end
      1:  begin op = 'h33; f3 = 6; end
      default: begin op = 'h33; f3 = 7; end
    endcase
    w = op + f3 * 4096 + longint'(rs1) * 32768;
    case (fmt)
      "R": w += longint'(rd) * 128 + longint'(rs2) * (1 << 20) + f7 * (1 << 25);
      "I": w += longint'(rd) * 128 + (u % 4096) * (1 << 20);
      "H": w += longint'(rd) * 128 + (u % 64) * (1 << 20) + f7 * (1 << 26);
      "S": w += (u % 32) * 128 + longint'(rs2) * (1 << 20) + ((u / 32) % 128) * (1 << 25);
      "B": w += longint'(rs2) * (1 << 20) + ((u / 2048) % 2) * 128 + ((u / 2) % 16) * 256
              + ((u / 32) % 64) * (1 << 25) + ((u / 4096) % 2) * (longint'(1) << 31);
      default: w = op + longint'(rd) * 128 + ((u / 4096) % 256) * 4096
              + ((u / 2048) % 2) * (1 << 20) + ((u / 2) % 1024) * (1 << 21)
              + ((u / (1 << 20)) % 2) * (longint'(1) << 31);
    endcase
    return w[31:0];
  endfunction

  task automatic send(input logic [22:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [20:0] imm, input logic [31:0] exp_w);
    exp_t e;
    bit   ok = 1'b0;
    in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else if ($countones(t) == 1) begin
      e.addr = m_addr; e.word = exp_w;
      exp_q.push_back(e);
      m_addr = m_addr + 30'd1;
    end else begin
      m_err = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d writes pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_wen && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: addr %h data %h, required no write", mem_addr_I, mem_wdata_I);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", {2'b0, mem_addr_I}, {2'b0, e.addr});
        check("wr_data", mem_wdata_I, e.word);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) mem_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] t;
    int          k;
    logic [4:0]  rd, rs1, rs2;
    logic [20:0] imm;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", {31'b0, mem_wen}, 32'd0);
    check("rst_addr", {2'b0, mem_addr_I}, {2'b0, BASE});
    check("rst_wdata", mem_wdata_I, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    send(23'h000100, 5'd3, 5'd1, 5'd2, 21'd0, 32'h002081B3);
    drain();
    check("addr_after_add", {2'b0, mem_addr_I}, {2'b0, BASE + 30'd1});

    send(23'h010000, 5'd1, 5'd0, 5'd0, 21'h1FFFFF, 32'hFFF00093);
    send(23'h020000, 5'd0, 5'd1, 5'd2, 21'd8, 32'h0020B423);
    send(23'h000200, 5'd5, 5'd5, 5'd0, 21'd3, 32'h4032D293);
    send(23'h100000, 5'd0, 5'd1, 5'd2, 21'h1FFFFC, 32'hFE208EE3);
    send(23'h400000, 5'd1, 5'd0, 5'd0, 21'd8, 32'h008000EF);
    drain();
    check("addr_wrapped", {2'b0, mem_addr_I}, 32'd4);

    mem_ready = 1'b0;
    send(23'h000080, 5'd7, 5'd8, 5'd9, 21'd0, 32'h409403B3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_wen", {31'b0, mem_wen}, 32'd1);
      check("stall_ready", {31'b0, in_ready}, 32'd0);
      check("stall_data", mem_wdata_I, 32'h409403B3);
      check("stall_addr", {2'b0, mem_addr_I}, {2'b0, m_addr - 30'd1});
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    drain();

    send(23'h000000, 5'd1, 5'd1, 5'd1, 21'd0, 32'h0);
    check("err_zero_type", {31'b0, err}, 32'd1);
    check("no_wen_zero_type", {31'b0, mem_wen}, 32'd0);
    send(23'h000003, 5'd1, 5'd1, 5'd1, 21'd0, 32'h0);
    check("err_multi_type", {31'b0, err}, {31'b0, m_err});
    check("no_wen_multi_type", {31'b0, mem_wen}, 32'd0);
    send(23'h000100, 5'd3, 5'd1, 5'd2, 21'd0, 32'h002081B3);
    drain();
    check("err_sticky", {31'b0, err}, 32'd1);

    mem_ready = 1'b0;
    send(23'h000001, 5'd4, 5'd5, 5'd6, 21'd0, 32'h0062F233);
    start = 1'b1;
    #1;
    check("start_blocks_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.delete();
    m_addr = BASE; m_err = 1'b0;
    check("start_wen", {31'b0, mem_wen}, 32'd0);
    check("start_addr", {2'b0, mem_addr_I}, {2'b0, BASE});
    check("start_err", {31'b0, err}, 32'd0);
    mem_ready = 1'b1;

    rdy_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31)); imm = 21'($urandom);
      k = $urandom_range(0, 22);
      if ($urandom_range(0, 9) == 0) t = 23'($urandom) & 23'h7FFFFF;
      else t = 23'b1 << k;
      send(t, rd, rs1, rs2, imm, ref_enc(k, rd, rs1, rs2, imm));
    end
    drain();
    rdy_rand = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    check("err_after_random", {31'b0, err}, {31'b0, m_err});

    mem_ready = 1'b0;
    send(23'h000010, 5'd2, 5'd3, 5'd4, 21'd0, 32'h0041C133);
    rst_n = 1'b0;
    #1;
    check("midwr_rst_wen", {31'b0, mem_wen}, 32'd0);
    check("midwr_rst_addr", {2'b0, mem_addr_I}, {2'b0, BASE});
    check("midwr_rst_wdata", mem_wdata_I, 32'd0);
    check("midwr_rst_err", {31'b0, err}, 32'd0);
    exp_q.delete();
    m_addr = BASE; m_err = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    send(23'h000100, 5'd3, 5'd1, 5'd2, 21'd0, 32'h002081B3);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
